cache_fill_fsm: RTL and testbench

- Miss-handling controller between the 2-way cache and 16-bit main memory.
- On a cache miss it fetches the full 16-byte block: 8 words, with word addresses at 2-byte steps.
- Memory is pipelined, so one read request is issued per cycle; data returns a fixed number of cycles later.
- Each returned word is streamed into the cache data array. The tag/metadata write is signalled with the last word.

---
 rtl/cache_fill_fsm.sv | 103 ++++++++++
 tb/tb_cache_fill_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a 16-byte block as 8 pipelined 16-bit reads
// and streams each returned word into the cache data array, tagging on the last word.
//
// state | meaning
// IDLE  | waiting for a miss, all outputs quiet
// FILL  | issuing block reads and writing returned words, pipeline stalled
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] fill_data
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [3:0] FULL_CNT = 4'(WORDS_PER_BLOCK);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [3:0]        issue_cnt;
    logic [3:0]        recv_cnt;
    logic              issue_go;
    logic              recv_go;

    assign issue_go = (state == FILL) && (issue_cnt < FULL_CNT);
    assign recv_go  = (state == FILL) && memory_data_valid && (recv_cnt < FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (miss_detected) begin
                    base      <= miss_address & 16'hFFF0;
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                end
            end else begin
                if (issue_go)
                    issue_cnt <= issue_cnt + 4'd1;
                if (recv_go)
                    recv_cnt <= recv_cnt + 4'd1;
            end
        end
    end

    // Offsets stay inside the aligned block, so no carry into base[15:4].
    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_addr       = '0;
        fill_data        = '0;
        case (state)
            IDLE: begin
                if (miss_detected)
                    state_nxt = FILL;
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_go) begin
                    mem_read_en    = 1'b1;
                    memory_address = base + {12'b0, issue_cnt[2:0], 1'b0};
                end
                if (recv_go) begin
                    write_data_array = 1'b1;
                    cache_addr       = base + {12'b0, recv_cnt[2:0], 1'b0};
                    fill_data        = memory_data;
                    if (recv_cnt == LAST_CNT) begin
                        write_tag_array = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a pipelined memory with configurable
// latency and valid gaps, checked against a block-fill reference model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_addr;
    logic [15:0] fill_data;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_addr        (cache_addr),
        .fill_data         (fill_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rsp_t;

    rsp_t        q[$];
    int          cyc;
    int          lat;
    int          gap;
    int          errors;
    int          checks;
    logic        m_busy;
    logic [15:0] m_base;
    int          m_req;
    int          m_wr;
    int          busy_cycles;
    int          writes_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'h0);
        chk({tag, "_rd_en"}, 32'(mem_read_en), 32'h0);
        chk({tag, "_mem_addr"}, 32'(memory_address), 32'h0);
        chk({tag, "_wr_data"}, 32'(write_data_array), 32'h0);
        chk({tag, "_wr_tag"}, 32'(write_tag_array), 32'h0);
        chk({tag, "_cache_addr"}, 32'(cache_addr), 32'h0);
        chk({tag, "_fill_data"}, 32'(fill_data), 32'h0);
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model at posedge.
    task automatic cycle(input logic miss, input logic [15:0] addr, input logic spur);
        logic        wr;
        logic        rd;
        logic [15:0] exp_rd_addr;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        if (spur) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
        end else if (q.size() > 0 && q[0].due <= cyc && (gap == 0 || (cyc % 2) == 1)) begin
            memory_data_valid = 1'b1;
            memory_data       = q[0].d;
            void'(q.pop_front());
        end
        @(negedge clk);
        wr          = m_busy && memory_data_valid && (m_wr < 8);
        rd          = m_busy && (m_req < 8);
        exp_rd_addr = rd ? m_base + 16'(2 * m_req) : 16'h0;
        chk("busy", 32'(fsm_busy), 32'(m_busy));
        chk("rd_en", 32'(mem_read_en), 32'(rd));
        chk("mem_addr", 32'(memory_address), 32'(exp_rd_addr));
        chk("wr_data", 32'(write_data_array), 32'(wr));
        chk("wr_tag", 32'(write_tag_array), 32'(wr && (m_wr == 7)));
        if (wr) begin
            chk("cache_addr", 32'(cache_addr), 32'(m_base + 16'(2 * m_wr)));
            chk("fill_data", 32'(fill_data), 32'(memory_data));
        end
        if (mem_read_en === 1'b1)
            q.push_back('{cyc + lat, 16'($urandom)});
        if (fsm_busy === 1'b1)
            busy_cycles++;
        if (write_data_array === 1'b1)
            writes_seen++;
        @(posedge clk);
        if (m_busy) begin
            if (m_req < 8)
                m_req++;
            if (wr)
                m_wr++;
            if (m_wr == 8)
                m_busy = 1'b0;
        end else if (miss) begin
            m_busy = 1'b1;
            m_base = addr & 16'hFFF0;
            m_req  = 0;
            m_wr   = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic finish_fill();
        int n = 0;
        while (m_busy && n < 200) begin
            cycle(1'b0, 16'h0, 1'b0);
            n++;
        end
        chk("fill_timeout", 32'(m_busy), 32'h0);
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        cyc               = 0;
        lat               = 4;
        gap               = 0;
        m_busy            = 1'b0;
        m_base            = 16'h0;
        m_req             = 0;
        m_wr              = 0;
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data       = 16'h0;
        memory_data_valid = 1'b0;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic fill, latency 4
        busy_cycles = 0;
        writes_seen = 0;
        cycle(1'b1, 16'h1234, 1'b0);
        finish_fill();
        chk("t1_busy_len", 32'(busy_cycles), 32'd12);
        chk("t1_writes", 32'(writes_seen), 32'd8);

        // Spurious valid while idle
        writes_seen = 0;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 16'h0, 1'b1);
        chk("idle_writes", 32'(writes_seen), 32'd0);

        // Valid gaps plus a spurious miss during the fill
        gap         = 1;
        lat         = 2;
        writes_seen = 0;
        cycle(1'b1, 16'h2468, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 16'h9990, 1'b0);
        finish_fill();
        chk("t2_writes", 32'(writes_seen), 32'd8);
        gap = 0;

        // Top-of-memory block
        lat = 3;
        cycle(1'b1, 16'hFFFF, 1'b0);
        finish_fill();

        // Reset in the middle of a fill
        lat = 4;
        cycle(1'b1, 16'h0AB6, 1'b0);
        for (int n = 0; n < 100 && m_wr < 3; n++)
            cycle(1'b0, 16'h0, 1'b0);
        chk("t4_three_words", 32'(m_wr), 32'd3);
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
        rst               = 1'b1;
        #1;
        chk_all_zero("midreset");
        m_busy = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b1);
        writes_seen = 0;
        cycle(1'b1, 16'h0040, 1'b0);
        finish_fill();
        chk("t4_refill_writes", 32'(writes_seen), 32'd8);

        // Back-to-back misses
        lat = 5;
        cycle(1'b1, 16'h0100, 1'b0);
        finish_fill();
        writes_seen = 0;
        cycle(1'b1, 16'h0400, 1'b0);
        finish_fill();
        chk("t5_writes", 32'(writes_seen), 32'd8);

        // Randomized fills
        for (int k = 0; k < 6; k++) begin
            lat         = int'($urandom_range(1, 7));
            gap         = int'($urandom_range(0, 1));
            writes_seen = 0;
            cycle(1'b1, 16'($urandom), 1'b0);
            for (int i = 0; i < 3; i++)
                cycle($urandom_range(0, 1) == 1, 16'($urandom), 1'b0);
            finish_fill();
            chk("rand_writes", 32'(writes_seen), 32'd8);
            cycle(1'b0, 16'h0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
